// File: rtl/neocore_pkg.sv
// Shared fetch-stage types and constants for the neocore front end.
package neocore_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } fetch_state_e;

  localparam int FETCH_WORD_BYTES = 4;

  function automatic logic [31:0] next_fetch_pc(input logic [31:0] pc);
    return pc + 32'(FETCH_WORD_BYTES);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO with a combinational head; used for pending addresses and fetched words.
module fetch_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  // Clear wins over everything; popping an empty FIFO is a no-op.
  assign do_push = push && !clear;
  assign do_pop  = pop && !clear && (count_reg != '0);

  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == PW'(gi))) begin
          mem_reg[gi] <= push_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= bump(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= bump(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/fetch_redirect_unit.sv
// Instruction fetch with credit-limited requests and redirect/discard handling.
// Optional redirect statistics counter enabled by FETCH_REDIRECT_STATS_EN.
module fetch_redirect_unit
  import neocore_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        fetch_valid,
  input  logic        fetch_ready,
  output logic [31:0] fetch_pc,
  output logic [31:0] fetch_data
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [15:0] redirect_count
`endif
);

  localparam int CW = $clog2(DEPTH + 1);

  fetch_state_e  state_reg, state_next;
  logic [31:0]   pc_reg, pc_next;
  logic [CW-1:0] discard_reg, discard_next;
  logic [CW-1:0] inflight, inflight_next;
  logic [CW-1:0] bufcnt;
  logic [CW:0]   credit_used;
  logic [31:0]   pend_addr;
  logic [63:0]   out_head;
  logic          req_fire;
  logic          rsp_fire;
  logic          rsp_keep;
  logic          out_pop;

  // Every accepted request reserves a slot in the output FIFO until it is consumed.
  assign credit_used    = {1'b0, inflight} + {1'b0, bufcnt};
  assign imem_req_valid = (state_reg != BOOT) && !redirect_valid
                          && (credit_used < (CW+1)'(DEPTH));
  assign imem_req_addr  = pc_reg;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_fire       = imem_rsp_valid && (inflight != '0);
  assign rsp_keep       = rsp_fire && (discard_reg == '0) && !redirect_valid;

  assign fetch_valid = (bufcnt != '0) && !redirect_valid;
  assign fetch_pc    = (bufcnt != '0) ? out_head[63:32] : 32'h0;
  assign fetch_data  = (bufcnt != '0) ? out_head[31:0]  : 32'h0;
  assign out_pop     = fetch_valid && fetch_ready;

  always_comb begin
    inflight_next = inflight;
    if (req_fire && !rsp_fire) begin
      inflight_next = inflight + CW'(1);
    end else if (!req_fire && rsp_fire) begin
      inflight_next = inflight - CW'(1);
    end

    // A redirect re-arms the discard count from scratch rather than adding to it.
    discard_next = discard_reg;
    if (redirect_valid) begin
      discard_next = inflight_next;
    end else if (rsp_fire && (discard_reg != '0)) begin
      discard_next = discard_reg - CW'(1);
    end

    pc_next = pc_reg;
    if (redirect_valid) begin
      pc_next = redirect_pc;
    end else if (req_fire) begin
      pc_next = next_fetch_pc(pc_reg);
    end

    state_next = state_reg;
    case (state_reg)
      BOOT:        state_next = RUN;
      RUN, FLUSH:  state_next = (discard_next != '0) ? FLUSH : RUN;
      default:     state_next = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= BOOT;
      pc_reg      <= RESET_PC;
      discard_reg <= '0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      discard_reg <= discard_next;
    end
  end

  fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (req_fire),
    .push_data (pc_reg),
    .pop       (rsp_fire),
    .head      (pend_addr),
    .count     (inflight)
  );

  fetch_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (rsp_keep),
    .push_data ({pend_addr, imem_rsp_data}),
    .pop       (out_pop),
    .head      (out_head),
    .count     (bufcnt)
  );

`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] redirect_count_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      redirect_count_reg <= '0;
    end else if (redirect_valid && (redirect_count_reg != 16'hFFFF)) begin
      redirect_count_reg <= redirect_count_reg + 16'd1;
    end
  end

  assign redirect_count = redirect_count_reg;
`endif

  // Memory must never answer a request that was not made.
  rsp_without_request: assert property (
    @(posedge clk) disable iff (!rst) !(imem_rsp_valid && (inflight == '0))
  );

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench for fetch_redirect_unit with an in-order memory model (data = ~addr).
module tb_fetch_redirect_unit;
  import neocore_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b1;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_data;
`ifdef FETCH_REDIRECT_STATS_EN
  logic [15:0] redirect_count;
`endif

  fetch_redirect_unit #(.RESET_PC(32'h0000_0100), .DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .fetch_valid    (fetch_valid),
    .fetch_ready    (fetch_ready),
    .fetch_pc       (fetch_pc),
`ifdef FETCH_REDIRECT_STATS_EN
    .redirect_count (redirect_count),
`endif
    .fetch_data     (fetch_data)
  );

  always #5 clk = ~clk;

  int          n_total = 0;
  int          n_bad   = 0;
  int          nreq    = 0;
  logic        rsp_en  = 1'b0;
  logic [31:0] mq [$];
  logic [31:0] acc [$];
  logic [63:0] dlv [$];

  logic        s_req_valid, s_fetch_valid;
  logic [31:0] s_req_addr, s_fetch_pc, s_fetch_data;
  logic [1:0]  s_state;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  function automatic logic [63:0] dlv_at(input int i);
    return (i < dlv.size()) ? dlv[i] : 64'hDEAD_DEAD_DEAD_DEAD;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc.size()) ? acc[i] : 32'hDEAD_DEAD;
  endfunction

  // Called at a falling edge: drive memory response, sample, book the coming rising edge.
  task automatic cyc();
    imem_rsp_valid = rsp_en && (mq.size() > 0);
    imem_rsp_data  = imem_rsp_valid ? ~mq[0] : 32'h0;
    #1;
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_fetch_valid = fetch_valid;
    s_fetch_pc    = fetch_pc;
    s_fetch_data  = fetch_data;
    s_state       = dut.state_reg;
    if (imem_rsp_valid) void'(mq.pop_front());
    if (imem_req_valid && imem_req_ready) begin
      mq.push_back(imem_req_addr);
      acc.push_back(imem_req_addr);
      nreq++;
    end
    if (fetch_valid && fetch_ready) dlv.push_back({fetch_pc, fetch_data});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    fetch_ready = 1'b1;
    imem_req_ready = 1'b1;
    rsp_en = 1'b0;
    mq.delete();
    cyc();
    cyc();
    acc.delete();
    dlv.delete();
    nreq = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);

    // Reset values, boot cycle and first requests
    do_reset();
    check_eq("rst_req_valid", 64'(s_req_valid), 64'h0);
    check_eq("rst_fetch_valid", 64'(s_fetch_valid), 64'h0);
    check_eq("rst_fetch_pc", 64'(s_fetch_pc), 64'h0);
    check_eq("rst_fetch_data", 64'(s_fetch_data), 64'h0);
    rsp_en = 1'b1;
    rst = 1'b1;
    cyc();
    check_eq("boot_no_req", 64'(s_req_valid), 64'h0);
    check_eq("boot_state", 64'(s_state), 64'(BOOT));
    cyc();
    check_eq("first_req", 64'({s_req_valid, s_req_addr}), 64'h1_0000_0100);
    cyc();
    check_eq("second_req", 64'({s_req_valid, s_req_addr}), 64'h1_0000_0104);
    repeat (10) cyc();
    check_eq("run_word0", dlv_at(0), 64'h0000_0100_FFFF_FEFF);
    check_eq("run_word1", dlv_at(1), 64'h0000_0104_FFFF_FEFB);
    check_eq("run_word2", dlv_at(2), 64'h0000_0108_FFFF_FEF7);

    // Decode stalled: credit caps requests at DEPTH
    do_reset();
    rsp_en = 1'b1;
    fetch_ready = 1'b0;
    rst = 1'b1;
    repeat (12) cyc();
    check_eq("stall_nreq", 64'(nreq), 64'd2);
    check_eq("stall_head", 64'({s_fetch_valid, s_fetch_pc}), 64'h1_0000_0100);
    fetch_ready = 1'b1;
    repeat (6) cyc();
    check_eq("stall_word0", dlv_at(0), 64'h0000_0100_FFFF_FEFF);
    check_eq("stall_word1", dlv_at(1), 64'h0000_0104_FFFF_FEFB);
    check_eq("stall_word2_pc", 64'(dlv_at(2) >> 32), 64'h0000_0108);

    // Redirect with two requests in flight
    do_reset();
    rsp_en = 1'b0;
    rst = 1'b1;
    repeat (4) cyc();
    check_eq("t3_inflight", 64'(nreq), 64'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_2000;
    acc.delete();
    dlv.delete();
    cyc();
    check_eq("t3_no_req_on_redirect", 64'(s_req_valid), 64'h0);
    redirect_valid = 1'b0;
    rsp_en = 1'b1;
    cyc();
    check_eq("t3_flush_state", 64'(s_state), 64'(FLUSH));
    repeat (8) cyc();
    check_eq("t3_run_state", 64'(s_state), 64'(RUN));
    check_eq("t3_first_req", 64'(acc_at(0)), 64'h0000_2000);
    check_eq("t3_first_word", dlv_at(0), 64'h0000_2000_FFFF_DFFF);

    // Redirect coinciding with a response and with decode ready
    do_reset();
    rsp_en = 1'b0;
    fetch_ready = 1'b0;
    rst = 1'b1;
    repeat (4) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_3000;
    rsp_en = 1'b1;
    fetch_ready = 1'b1;
    dlv.delete();
    cyc();
    check_eq("t4_fetch_low", 64'(s_fetch_valid), 64'h0);
    check_eq("t4_discard", 64'(dut.discard_reg), 64'd1);
    redirect_valid = 1'b0;
    cyc();
    check_eq("t4_out_empty", 64'(s_fetch_valid), 64'h0);
    repeat (8) cyc();
    check_eq("t4_first_word", dlv_at(0), 64'h0000_3000_FFFF_CFFF);

    // Redirect while the output FIFO is full
    do_reset();
    rsp_en = 1'b1;
    fetch_ready = 1'b0;
    rst = 1'b1;
    repeat (8) cyc();
    check_eq("t5_buffer_full", 64'(s_fetch_valid), 64'h1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_4000;
    fetch_ready = 1'b1;
    dlv.delete();
    cyc();
    check_eq("t5_fetch_low", 64'(s_fetch_valid), 64'h0);
    redirect_valid = 1'b0;
    cyc();
    check_eq("t5_req_next_cycle", 64'({s_req_valid, s_req_addr}), 64'h1_0000_4000);
    repeat (6) cyc();
    check_eq("t5_first_word", dlv_at(0), 64'h0000_4000_FFFF_BFFF);

    // Back-to-back redirects, last one at the top of the address space
    do_reset();
    rsp_en = 1'b1;
    rst = 1'b1;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_5000;
    cyc();
    redirect_pc = 32'h0000_6000;
    cyc();
    redirect_pc = 32'hFFFF_FFFC;
    acc.delete();
    dlv.delete();
    cyc();
    redirect_valid = 1'b0;
    repeat (12) cyc();
    check_eq("wrap_req0", 64'(acc_at(0)), 64'hFFFF_FFFC);
    check_eq("wrap_req1", 64'(acc_at(1)), 64'h0000_0000);
    check_eq("wrap_word0", dlv_at(0), 64'hFFFF_FFFC_0000_0003);
    check_eq("wrap_word1", dlv_at(1), 64'h0000_0000_FFFF_FFFF);
`ifdef FETCH_REDIRECT_STATS_EN
    check_eq("redirect_count", 64'(redirect_count), 64'd3);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_unit.md
FETCH_REDIRECT_UNIT -- requirements
Module: fetch_redirect_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, the combined in-flight-plus-buffered word limit (legal range 2..4).
REQ-003 SHALL have port clk  input  1  the single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port redirect_valid  input  1  a taken branch or JSR is resolved this cycle.
REQ-006 SHALL have port redirect_pc  input  32  the branch target.
REQ-007 SHALL have port imem_req_valid  output  1  an instruction-memory request is offered.
REQ-008 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-009 SHALL have port imem_req_addr  output  32  the request address.
REQ-010 SHALL have port imem_rsp_valid  input  1  a response is present; responses are in order, one per accepted request.
REQ-011 SHALL have port imem_rsp_data  input  32  the response word.
REQ-012 SHALL have port fetch_valid  output  1  a word is offered to decode.
REQ-013 SHALL have port fetch_ready  input  1  decode accepts the word.
REQ-014 SHALL have port fetch_pc  output  32  the address of the offered word.
REQ-015 SHALL have port fetch_data  output  32  the offered word.

Function
REQ-016 SHALL keep the FSM states BOOT, RUN and FLUSH; reset enters BOOT; BOOT moves to RUN after one cycle with no request issued.
REQ-017 SHALL drive imem_req_valid = (state != BOOT) && !redirect_valid && (inflight + bufcnt < DEPTH).
REQ-018 SHALL drive imem_req_addr from the pc register.
REQ-019 SHALL, on a request handshake, set pc to pc + 4 (mod 2^32, wrapping past 32'hFFFF_FFFC to 0) and push pc onto the pending-address FIFO (DEPTH entries).
REQ-020 SHALL, on imem_rsp_valid, pop the pending FIFO; if discard > 0, drop the word and decrement discard; otherwise write {addr, data} into the output FIFO (DEPTH entries).
REQ-021 SHALL present the output-FIFO head on fetch_valid/fetch_pc/fetch_data; the entry pops on fetch_valid && fetch_ready.
REQ-022 SHALL accept a same-cycle push and pop on either FIFO without loss; a full FIFO is never pushed, guaranteed by the credit rule in REQ-017.
REQ-023 SHALL, on redirect_valid, load pc with redirect_pc, empty the output FIFO, and force fetch_valid low the same cycle.
REQ-024 SHALL, on redirect_valid, set discard to the post-cycle inflight count (any same-cycle response is already dropped).
REQ-025 SHALL enter FLUSH when discard becomes nonzero and return to RUN when it reaches 0; new requests remain legal in FLUSH.
REQ-026 SHALL treat redirect_valid in BOOT as loading pc, with BOOT still lasting exactly one cycle.
REQ-027 SHALL let a later redirect override an earlier one; discard is recomputed and never accumulated.
REQ-028 SHALL treat imem_rsp_valid with inflight == 0 as a protocol error and ignore it (assertion in simulation).
REQ-029 SHALL make redirect latency 1 cycle: the request to redirect_pc is offered in the cycle after redirect_valid.

Reset
REQ-030 SHALL, on rst low, asynchronously set pc = RESET_PC, state = BOOT, inflight = 0, discard = 0, and both FIFOs empty.
REQ-031 SHALL hold imem_req_valid = 0, fetch_valid = 0, fetch_pc = 0 and fetch_data = 0 during reset.
REQ-032 SHALL lose any in-flight responses when reset is asserted mid-operation; memory is reset alongside.

Configuration
REQ-033 SHALL, with FETCH_REDIRECT_STATS_EN defined, add output redirect_count (16 bits) counting redirect_valid cycles, saturating at 16'hFFFF and reset to 0.
REQ-034 SHALL, without FETCH_REDIRECT_STATS_EN, have no port and no counter logic.

Structure
REQ-035 SHALL place the fetch_state_e enum and the constant FETCH_WORD_BYTES = 4 in neocore_pkg.
REQ-036 SHALL implement both FIFOs as instances of one sub-module, fetch_fifo (parameterised width and depth).

Verification
REQ-037 SHALL cover reset release with RESET_PC = 32'h100 and memory always ready: first request in cycle 2 at 32'h100, then 32'h104; decode sees pc 32'h100 with the correct data.
REQ-038 SHALL cover fetch_ready = 0 for 10 cycles: exactly DEPTH = 2 requests issued, no overflow, words 32'h100 and 32'h104 delivered in order afterwards.
REQ-039 SHALL cover a redirect to 32'h2000 with 2 in flight: both stale responses dropped, next fetch_pc = 32'h2000, FLUSH then RUN.
REQ-040 SHALL cover a redirect coinciding with imem_rsp_valid and with fetch_ready: discard = 1, output FIFO empty, and no stale word delivered.
REQ-041 SHALL cover pc = 32'hFFFF_FFFC: the next request address is 32'h0000_0000.
REQ-042 SHALL cover FETCH_REDIRECT_STATS_EN with 3 redirects: redirect_count = 3; with the macro undefined, the build has no port.
